multicycle_sequencer: RTL and testbench

//  Multi-cycle controller for the RV64 datapath: steps each instruction through FETCH, DECODE,

---
 rtl/seq_pkg.sv | 22 ++
 rtl/seq_timeout_counter.sv | 29 ++
 rtl/multicycle_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types and constants for the multi-cycle instruction sequencer.
// The SEQ_PERF_CNT_EN build option is handled in multicycle_sequencer.
package seq_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        DECODE  = 3'd2,
        EXECUTE = 3'd3,
        MEM     = 3'd4,
        WB      = 3'd5,
        HALT    = 3'd6
    } state_t;

    localparam logic [2:0] ERR_NONE       = 3'd0;
    localparam logic [2:0] ERR_FETCH      = 3'd1;
    localparam logic [2:0] ERR_DECODE     = 3'd2;
    localparam logic [2:0] ERR_MEM        = 3'd3;
    localparam logic [2:0] ERR_IFETCH_TMO = 3'd4;
    localparam logic [2:0] ERR_DMEM_TMO   = 3'd5;

endpackage

// File: rtl/seq_timeout_counter.sv
// Wait-cycle counter shared by the fetch and data-access handshakes.
// hit flags the last permitted cycle without an acknowledge.
module seq_timeout_counter #(
    parameter int LIMIT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic hit
);

    localparam int W = (LIMIT > 2) ? $clog2(LIMIT) : 1;

    logic [W-1:0] cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + W'(1);
        end
    end

    assign hit = en && (cnt == W'(LIMIT - 1));

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WB controller with handshake timeouts and fault halt.
// Define SEQ_PERF_CNT_EN to build the cycle and retired-instruction counters.
module multicycle_sequencer
    import seq_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run,
    output logic             imem_req,
    input  logic             imem_ack,
    input  logic             inv_addr,
    input  logic             inv_op,
    input  logic             inv_func,
    input  logic             inv_reg_addr,
    input  logic             ctl_regwrite,
    input  logic             ctl_memread,
    input  logic             ctl_memwrite,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ack,
    input  logic             inv_mem_addr,
    output logic             ir_load,
    output logic             pc_write,
    output logic             reg_we,
    output logic [2:0]       state,
    output logic             halted,
    output logic [2:0]       err_code,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    state_t cur;
    logic   lat_regwrite;
    logic   lat_memread;
    logic   lat_memwrite;

    logic waiting;
    logic ack_now;
    logic tmo_en;
    logic tmo_clear;
    logic tmo_hit;

    // The counter only runs while a handshake is outstanding, so it is already zero on entry.
    assign waiting   = (cur == FETCH) || (cur == MEM);
    assign ack_now   = (cur == FETCH) ? imem_ack : dmem_ack;
    assign tmo_en    = waiting && !ack_now;
    assign tmo_clear = !tmo_en;

    seq_timeout_counter #(.LIMIT(MEM_TIMEOUT)) u_timeout (
        .clock (clock),
        .reset (reset),
        .clear (tmo_clear),
        .en    (tmo_en),
        .hit   (tmo_hit)
    );

    assign state = cur;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cur          <= IDLE;
            imem_req     <= 1'b0;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            ir_load      <= 1'b0;
            pc_write     <= 1'b0;
            reg_we       <= 1'b0;
            halted       <= 1'b0;
            err_code     <= ERR_NONE;
            lat_regwrite <= 1'b0;
            lat_memread  <= 1'b0;
            lat_memwrite <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every branch read the pre-edge state consistently.
            ir_load  <= 1'b0;
            pc_write <= 1'b0;
            reg_we   <= 1'b0;
            case (cur)
                IDLE: begin
                    if (run) begin
                        cur      <= FETCH;
                        imem_req <= 1'b1;
                    end
                end
                FETCH: begin
                    if (imem_ack) begin
                        imem_req <= 1'b0;
                        if (inv_addr) begin
                            cur      <= HALT;
                            halted   <= 1'b1;
                            err_code <= ERR_FETCH;
                        end else begin
                            cur     <= DECODE;
                            ir_load <= 1'b1;
                        end
                    end else if (tmo_hit) begin
                        imem_req <= 1'b0;
                        cur      <= HALT;
                        halted   <= 1'b1;
                        err_code <= ERR_IFETCH_TMO;
                    end
                end
                DECODE: begin
                    lat_regwrite <= ctl_regwrite;
                    lat_memread  <= ctl_memread;
                    lat_memwrite <= ctl_memwrite;
                    if (inv_op || inv_func || inv_reg_addr) begin
                        cur      <= HALT;
                        halted   <= 1'b1;
                        err_code <= ERR_DECODE;
                    end else begin
                        cur <= EXECUTE;
                        // Branch/nop retires in EXECUTE, so its PC update must land there.
                        if (!(ctl_memread || ctl_memwrite || ctl_regwrite)) begin
                            pc_write <= 1'b1;
                        end
                    end
                end
                EXECUTE: begin
                    if (lat_memread || lat_memwrite) begin
                        cur      <= MEM;
                        dmem_req <= 1'b1;
                        dmem_we  <= lat_memwrite;
                    end else if (lat_regwrite) begin
                        cur      <= WB;
                        reg_we   <= 1'b1;
                        pc_write <= 1'b1;
                    end else if (run) begin
                        cur      <= FETCH;
                        imem_req <= 1'b1;
                    end else begin
                        cur <= IDLE;
                    end
                end
                MEM: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        if (inv_mem_addr) begin
                            cur      <= HALT;
                            halted   <= 1'b1;
                            err_code <= ERR_MEM;
                        end else if (lat_memwrite) begin
                            pc_write <= 1'b1;
                            if (run) begin
                                cur      <= FETCH;
                                imem_req <= 1'b1;
                            end else begin
                                cur <= IDLE;
                            end
                        end else begin
                            cur      <= WB;
                            reg_we   <= 1'b1;
                            pc_write <= 1'b1;
                        end
                    end else if (tmo_hit) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        cur      <= HALT;
                        halted   <= 1'b1;
                        err_code <= ERR_DMEM_TMO;
                    end
                end
                WB: begin
                    if (run) begin
                        cur      <= FETCH;
                        imem_req <= 1'b1;
                    end else begin
                        cur <= IDLE;
                    end
                end
                HALT: begin
                    cur <= HALT;
                end
                default: begin
                    cur <= IDLE;
                end
            endcase
        end
    end

`ifdef SEQ_PERF_CNT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            if (cur != IDLE && cur != HALT) begin
                cycle_cnt <= cycle_cnt + CNT_W'(1);
            end
            // Each retirement issues exactly one pc_write pulse.
            if (pc_write) begin
                instret_cnt <= instret_cnt + CNT_W'(1);
            end
        end
    end
`else
    assign cycle_cnt   = '0;
    assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench: scripted handshakes, pulse scoreboard and state/fault checks.
module tb_multicycle_sequencer;
    import seq_pkg::*;

    localparam int MEM_TIMEOUT = 16;
    localparam int CNT_W       = 32;

    localparam logic [2:0] P_IR = 3'b100;
    localparam logic [2:0] P_WB = 3'b011;
    localparam logic [2:0] P_PC = 3'b001;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             run = 1'b0;
    logic             imem_req;
    logic             imem_ack = 1'b0;
    logic             inv_addr = 1'b0;
    logic             inv_op = 1'b0;
    logic             inv_func = 1'b0;
    logic             inv_reg_addr = 1'b0;
    logic             ctl_regwrite = 1'b0;
    logic             ctl_memread = 1'b0;
    logic             ctl_memwrite = 1'b0;
    logic             dmem_req;
    logic             dmem_we;
    logic             dmem_ack = 1'b0;
    logic             inv_mem_addr = 1'b0;
    logic             ir_load;
    logic             pc_write;
    logic             reg_we;
    logic [2:0]       state;
    logic             halted;
    logic [2:0]       err_code;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] instret_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    logic [2:0] sb[$];
    longint exp_instret = 0;
    longint exp_cycles  = 0;

    multicycle_sequencer #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clock        (clk),
        .reset        (reset),
        .run          (run),
        .imem_req     (imem_req),
        .imem_ack     (imem_ack),
        .inv_addr     (inv_addr),
        .inv_op       (inv_op),
        .inv_func     (inv_func),
        .inv_reg_addr (inv_reg_addr),
        .ctl_regwrite (ctl_regwrite),
        .ctl_memread  (ctl_memread),
        .ctl_memwrite (ctl_memwrite),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_ack     (dmem_ack),
        .inv_mem_addr (inv_mem_addr),
        .ir_load      (ir_load),
        .pc_write     (pc_write),
        .reg_we       (reg_we),
        .state        (state),
        .halted       (halted),
        .err_code     (err_code),
        .cycle_cnt    (cycle_cnt),
        .instret_cnt  (instret_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] perf(input longint v);
`ifdef SEQ_PERF_CNT_EN
        return 64'(v) & ((64'd1 << CNT_W) - 64'd1);
`else
        return 64'(v & 0);
`endif
    endfunction

    // Every ir_load/reg_we/pc_write pulse must match the next predicted pulse.
    always @(negedge clk) begin : pulse_monitor
        logic [2:0] p;
        if (reset) begin
            p = {ir_load, reg_we, pc_write};
            if (p != 3'b000) begin
                if (sb.size() == 0) check("unexpected_pulse", 64'(p), 64'd0);
                else                check("pulse", 64'(p), 64'(sb.pop_front()));
            end
        end
    end

    task automatic do_reset();
        reset = 1'b0;
        run = 1'b0;
        {imem_ack, inv_addr, inv_op, inv_func, inv_reg_addr} = '0;
        {ctl_regwrite, ctl_memread, ctl_memwrite, dmem_ack, inv_mem_addr} = '0;
        repeat (2) @(negedge clk);
        sb.delete();
        exp_instret = 0;
        exp_cycles  = 0;
        reset = 1'b1;
    endtask

    task automatic wait_fetch();
        int n = 0;
        while (!imem_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("imem_req_wait", 64'(imem_req), 64'd1);
    endtask

    task automatic do_instr(input bit rd, input bit wr, input bit rw, input int i_wait,
                            input int d_wait, input bit dec_fault, input bit mem_fault,
                            input bit drop_run);
        bit mem_op = rd | wr;
        int n;
        sb.push_back(P_IR);
        if (!dec_fault && !(mem_op && mem_fault)) begin
            if (mem_op) sb.push_back(wr ? P_PC : P_WB);
            else        sb.push_back(rw ? P_WB : P_PC);
            exp_instret++;
        end
        wait_fetch();
        check("st_fetch", 64'(state), 64'(FETCH));
        ctl_regwrite = rw;
        ctl_memread  = rd;
        ctl_memwrite = wr;
        inv_op       = dec_fault;
        repeat (i_wait) @(negedge clk);
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        exp_cycles += i_wait + 2;
        check("st_decode", 64'(state), 64'(DECODE));
        @(negedge clk);
        {ctl_regwrite, ctl_memread, ctl_memwrite, inv_op} = '0;
        if (dec_fault) begin
            check("st_dec_halt", 64'(state), 64'(HALT));
            check("err_decode", 64'(err_code), 64'(ERR_DECODE));
            return;
        end
        exp_cycles += 1;
        check("st_execute", 64'(state), 64'(EXECUTE));
        if (mem_op) begin
            @(negedge clk);
            check("st_mem", 64'(state), 64'(MEM));
            check("dmem_we", 64'(dmem_we), 64'(wr));
            if (drop_run) run = 1'b0;
            n = dmem_req ? 1 : 0;
            repeat (d_wait) begin
                @(negedge clk);
                if (dmem_req) n++;
            end
            dmem_ack = 1'b1;
            inv_mem_addr = mem_fault;
            @(negedge clk);
            dmem_ack = 1'b0;
            inv_mem_addr = 1'b0;
            exp_cycles += d_wait + 1;
            check("dmem_req_cycles", 64'(n), 64'(d_wait + 1));
            check("dmem_req_drop", 64'(dmem_req), 64'd0);
            if (mem_fault) begin
                check("st_mem_halt", 64'(state), 64'(HALT));
                check("err_mem", 64'(err_code), 64'(ERR_MEM));
                return;
            end
            if (!wr) begin
                check("st_wb_load", 64'(state), 64'(WB));
                exp_cycles += 1;
                @(negedge clk);
            end
        end else begin
            @(negedge clk);
            if (rw) begin
                check("st_wb", 64'(state), 64'(WB));
                exp_cycles += 1;
                @(negedge clk);
            end
        end
        check("st_next", 64'(state), 64'(run ? FETCH : IDLE));
    endtask

    initial begin
        int n;
        do_reset();
        check("rst_state", 64'(state), 64'(IDLE));
        check("rst_reqs", 64'({imem_req, dmem_req, dmem_we}), 64'd0);
        check("rst_pulses", 64'({ir_load, reg_we, pc_write}), 64'd0);
        check("rst_halted", 64'(halted), 64'd0);
        check("rst_err", 64'(err_code), 64'(ERR_NONE));
        check("rst_cycles", 64'(cycle_cnt), perf(0));
        check("rst_instret", 64'(instret_cnt), perf(0));

        // Back-to-back ALU, load (3 waits), nop, then a store with run dropped in MEM.
        run = 1'b1;
        do_instr(0, 0, 1, 0, 0, 0, 0, 0);
        check("instret_alu", 64'(instret_cnt), perf(exp_instret));
        do_instr(1, 0, 1, 0, 3, 0, 0, 0);
        do_instr(0, 0, 0, 1, 0, 0, 0, 0);
        do_instr(0, 1, 0, 0, 0, 0, 0, 1);
        repeat (3) @(negedge clk);
        check("idle_after_drop", 64'(state), 64'(IDLE));
        check("instret_chain", 64'(instret_cnt), perf(exp_instret));
        check("cycles_chain", 64'(cycle_cnt), perf(exp_cycles));

        // Store hitting a bad address halts without retiring.
        run = 1'b1;
        do_instr(0, 1, 0, 0, 2, 0, 1, 0);
        n = 0;
        repeat (10) begin
            @(negedge clk);
            if (halted && state == HALT && !imem_req && !dmem_req) n++;
        end
        check("halt_hold", 64'(n), 64'd10);
        check("instret_no_retire", 64'(instret_cnt), perf(exp_instret));

        // Decode fault, then run toggling must not leave HALT.
        do_reset();
        run = 1'b1;
        do_instr(0, 0, 1, 0, 0, 1, 0, 0);
        run = 1'b0;
        repeat (3) @(negedge clk);
        run = 1'b1;
        repeat (5) @(negedge clk);
        check("dec_halt_stuck", 64'({state, halted, err_code}), 64'({HALT, 1'b1, ERR_DECODE}));

        // Fetch fault.
        do_reset();
        run = 1'b1;
        wait_fetch();
        imem_ack = 1'b1;
        inv_addr = 1'b1;
        @(negedge clk);
        {imem_ack, inv_addr} = '0;
        check("fetch_fault", 64'({state, halted, err_code}), 64'({HALT, 1'b1, ERR_FETCH}));

        // Withheld imem_ack: exactly MEM_TIMEOUT fetch cycles, then HALT.
        do_reset();
        run = 1'b1;
        wait_fetch();
        n = 0;
        while (state == FETCH && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("ifetch_tmo_cycles", 64'(n), 64'(MEM_TIMEOUT));
        check("ifetch_tmo", 64'({state, halted, err_code, imem_req}), 64'({HALT, 1'b1, ERR_IFETCH_TMO, 1'b0}));

        // Ack on the last permitted cycle wins over the timeout.
        do_reset();
        run = 1'b1;
        do_instr(0, 0, 1, MEM_TIMEOUT - 1, 0, 0, 0, 0);
        check("ack_wins_halted", 64'(halted), 64'd0);

        // Withheld dmem_ack on a store.
        do_reset();
        run = 1'b1;
        sb.push_back(P_IR);
        ctl_memwrite = 1'b1;
        wait_fetch();
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        repeat (2) @(negedge clk);
        ctl_memwrite = 1'b0;
        n = 0;
        while (state == MEM && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("dmem_tmo_cycles", 64'(n), 64'(MEM_TIMEOUT));
        check("dmem_tmo", 64'({state, err_code, dmem_req}), 64'({HALT, ERR_DMEM_TMO, 1'b0}));

        // Asynchronous reset in the middle of a load.
        do_reset();
        run = 1'b1;
        sb.push_back(P_IR);
        ctl_memread = 1'b1;
        wait_fetch();
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_rst_dmem_req", 64'(dmem_req), 64'd1);
        #2 reset = 1'b0;
        #1;
        check("async_rst_dmem_req", 64'(dmem_req), 64'd0);
        check("async_rst_state", 64'(state), 64'(IDLE));
        check("async_rst_cnts", 64'({cycle_cnt, instret_cnt}), 64'd0);
        ctl_memread = 1'b0;
        run = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
